// File: rtl/fc_layer_seq.sv
// ============================================================================
// fc_layer_seq : time-multiplexed fixed-point fully connected layer
//   forward pass (y = W*x + b) or backward error plus in-place weight update
// Revision 1.0
// ============================================================================
`default_nettype none

module fc_layer_seq #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int INPUT_DIM  = 4,
  parameter int OUTPUT_DIM = 4,
  parameter int LR_SHIFT   = 4,
  parameter int ACC_WIDTH  = 2*WIDTH+8
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic                                                   mode,
  input  logic [INPUT_DIM-1:0][WIDTH-1:0]                        input_data,
  input  logic [OUTPUT_DIM-1:0][WIDTH-1:0]                       output_error,
  input  logic                                                   wr_en,
  input  logic [((OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1)-1:0] wr_row,
  input  logic [$clog2(INPUT_DIM+1)-1:0]                         wr_col,
  input  logic [WIDTH-1:0]                                       wr_data,
  output logic                                                   busy,
  output logic                                                   done,
  output logic [OUTPUT_DIM-1:0][WIDTH-1:0]                       output_data,
  output logic [INPUT_DIM-1:0][WIDTH-1:0]                        input_error
);

  localparam int ROW_W = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1;
  localparam int COL_W = $clog2(INPUT_DIM+1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  generate
    if (ACC_WIDTH < 2*WIDTH + $clog2(INPUT_DIM+1) + 1) begin : g_acc_check
      $error("fc_layer_seq: ACC_WIDTH too small for overflow-free accumulation");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FWD  = 3'd1,
    S_BERR = 3'd2,
    S_BUPD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nx;

  logic signed [WIDTH-1:0]     w     [OUTPUT_DIM][INPUT_DIM+1];
  logic signed [WIDTH-1:0]     x_lat [INPUT_DIM];
  logic signed [WIDTH-1:0]     e_lat [OUTPUT_DIM];
  logic signed [ACC_WIDTH-1:0] acc, acc_nx;
  logic [ROW_W-1:0]            row;
  logic [COL_W-1:0]            col;

  logic signed [WIDTH-1:0]     w_sel, x_sel, e_sel, op_a, op_b;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, w_ext, e_ext, acc_shr, upd_sum;
  logic signed [WIDTH-1:0]     res, w_new;
  logic                        last_row, last_col;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
    else                  sat = v[WIDTH-1:0];
  endfunction

  assign last_row = (row == ROW_W'(OUTPUT_DIM-1));
  assign last_col = (col == COL_W'(INPUT_DIM));

  // Operand selection: col indexes the weight column, so x uses col-1 and bias has no x.
  always_comb begin
    w_sel = '0;
    x_sel = '0;
    e_sel = '0;
    for (int r = 0; r < OUTPUT_DIM; r++) begin
      for (int c = 0; c <= INPUT_DIM; c++) begin
        if (row == ROW_W'(r) && col == COL_W'(c)) w_sel = w[r][c];
      end
      if (row == ROW_W'(r)) e_sel = e_lat[r];
    end
    for (int c = 0; c < INPUT_DIM; c++) begin
      if (col == COL_W'(c+1)) x_sel = x_lat[c];
    end
  end

  assign op_a     = (state == S_BUPD) ? e_sel : w_sel;
  assign op_b     = (state == S_BERR) ? e_sel : x_sel;
  assign prod     = op_a * op_b;
  assign prod_ext = {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign w_ext    = {{(ACC_WIDTH-WIDTH){w_sel[WIDTH-1]}}, w_sel};
  assign e_ext    = {{(ACC_WIDTH-WIDTH){e_sel[WIDTH-1]}}, e_sel};

  always_comb begin
    acc_nx = acc;
    case (state)
      S_FWD: begin
        if (col == '0) acc_nx = w_ext <<< FRAC;
        else           acc_nx = acc + prod_ext;
      end
      S_BERR: begin
        if (row == '0) acc_nx = prod_ext;
        else           acc_nx = acc + prod_ext;
      end
      default: acc_nx = acc;
    endcase
  end

  assign acc_shr = acc_nx >>> FRAC;
  assign res     = sat(acc_shr);
  assign upd_sum = (col == '0) ? (w_ext + (e_ext >>> LR_SHIFT))
                               : (w_ext + (prod_ext >>> (FRAC + LR_SHIFT)));
  assign w_new   = sat(upd_sum);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = mode ? S_BERR : S_FWD;
      S_FWD:  if (last_row && last_col) state_nx = S_DONE;
      S_BERR: if (last_row && last_col) state_nx = S_BUPD;
      S_BUPD: if (last_row && last_col) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // BERR walks col = j+1 (outer) and row = i (inner) so the weight column needs no offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      row         <= '0;
      col         <= '0;
      output_data <= '0;
      input_error <= '0;
      for (int c = 0; c < INPUT_DIM; c++)  x_lat[c] <= '0;
      for (int r = 0; r < OUTPUT_DIM; r++) e_lat[r] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc <= '0;
            row <= '0;
            col <= mode ? COL_W'(1) : '0;
            for (int c = 0; c < INPUT_DIM; c++)  x_lat[c] <= input_data[c];
            for (int r = 0; r < OUTPUT_DIM; r++) e_lat[r] <= output_error[r];
          end
        end
        S_FWD: begin
          acc <= acc_nx;
          if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + ROW_W'(1);
            for (int r = 0; r < OUTPUT_DIM; r++) begin
              if (row == ROW_W'(r)) output_data[r] <= res;
            end
          end else begin
            col <= col + COL_W'(1);
          end
        end
        S_BERR: begin
          acc <= acc_nx;
          if (last_row) begin
            row <= '0;
            col <= last_col ? '0 : col + COL_W'(1);
            for (int c = 0; c < INPUT_DIM; c++) begin
              if (col == COL_W'(c+1)) input_error[c] <= res;
            end
          end else begin
            row <= row + ROW_W'(1);
          end
        end
        S_BUPD: begin
          if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < OUTPUT_DIM; r++) begin
      for (int c = 0; c <= INPUT_DIM; c++) begin
        if (reset) begin
          w[r][c] <= '0;
        end else if (state == S_IDLE && wr_en &&
                     wr_row == ROW_W'(r) && wr_col == COL_W'(c)) begin
          w[r][c] <= wr_data;
        end else if (state == S_BUPD && row == ROW_W'(r) && col == COL_W'(c)) begin
          w[r][c] <= w_new;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_seq.sv
// ============================================================================
// tb_fc_layer_seq : directed self-checking bench for fc_layer_seq (2x2, LR 2^-1)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fc_layer_seq;

  logic              clk;
  logic              reset;
  logic              start;
  logic              mode;
  logic [1:0][15:0]  input_data;
  logic [1:0][15:0]  output_error;
  logic              wr_en;
  logic [0:0]        wr_row;
  logic [1:0]        wr_col;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;
  logic [1:0][15:0]  output_data;
  logic [1:0][15:0]  input_error;

  int n_checks = 0;
  int n_fail   = 0;

  fc_layer_seq #(
    .WIDTH(16), .FRAC(8), .INPUT_DIM(2), .OUTPUT_DIM(2), .LR_SHIFT(1), .ACC_WIDTH(40)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .input_data(input_data), .output_error(output_error),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .done(done), .output_data(output_data), .input_error(input_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int r, input int c, input int v);
    @(negedge clk);
    wr_en = 1'b1; wr_row = 1'(r); wr_col = 2'(c); wr_data = 16'(v);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_x(input int a, input int b);
    input_data[0] = 16'(a); input_data[1] = 16'(b);
  endtask

  task automatic set_e(input int a, input int b);
    output_error[0] = 16'(a); output_error[1] = 16'(b);
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (done === 1'b1) begin cyc = k; break; end
    end
  endtask

  // Start sampled at cycle 0; returns at the negedge of the done cycle.
  task automatic run_op(input logic m, input int exp_done, input string tag,
                        input logic co_wr = 1'b0, input int co_col = 0, input int co_val = 0);
    int got;
    int gaps;
    got = -1; gaps = 0;
    @(negedge clk);
    mode = m; start = 1'b1;
    if (co_wr) begin
      wr_en = 1'b1; wr_row = 1'b0; wr_col = 2'(co_col); wr_data = 16'(co_val);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (busy !== 1'b1) gaps++;
      if (done === 1'b1) begin got = k; break; end
    end
    check({tag, "_done_cycle"}, got, exp_done);
    check({tag, "_busy_span"}, gaps, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int cyc;
    reset = 1'b1; start = 1'b0; mode = 1'b0; wr_en = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0; input_data = '0; output_error = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y0", $signed(output_data[0]), 0);
    check("rst_y1", $signed(output_data[1]), 0);
    check("rst_ie0", $signed(input_error[0]), 0);
    check("rst_ie1", $signed(input_error[1]), 0);

    set_x(256, 256);
    run_op(1'b0, 7, "fwd_zero");
    check("fwd_zero_y0", $signed(output_data[0]), 0);
    check("fwd_zero_y1", $signed(output_data[1]), 0);

    wr(0, 0, 256);  wr(0, 1, 512); wr(0, 2, 256);
    wr(1, 0, -256); wr(1, 1, 0);   wr(1, 2, 256);
    run_op(1'b0, 7, "fwd");
    check("fwd_y0", $signed(output_data[0]), 1024);
    check("fwd_y1", $signed(output_data[1]), 0);
    @(negedge clk);
    check("fwd_idle_busy", busy, 0);
    check("fwd_idle_done", done, 0);

    wr(0, 0, 0); wr(0, 1, 32767); wr(0, 2, 32767);
    set_x(32767, 32767);
    run_op(1'b0, 7, "satp");
    check("satp_y0", $signed(output_data[0]), 32767);
    check("satp_y1", $signed(output_data[1]), 32511);
    set_x(-32767, -32767);
    run_op(1'b0, 7, "satn");
    check("satn_y0", $signed(output_data[0]), -32768);
    check("satn_y1", $signed(output_data[1]), -32768);

    wr(0, 0, 0); wr(0, 1, 512); wr(0, 2, 0);
    wr(1, 0, 0); wr(1, 1, 0);   wr(1, 2, 0);
    set_x(512, 0); set_e(256, 0);
    run_op(1'b1, 11, "bwd");
    check("bwd_ie0", $signed(input_error[0]), 512);
    check("bwd_ie1", $signed(input_error[1]), 0);
    check("bwd_y0_held", $signed(output_data[0]), -32768);
    check("bwd_y1_held", $signed(output_data[1]), -32768);

    // Updated W[0] = [128, 768, 0], W[1] unchanged zero
    set_x(0, 0);
    run_op(1'b0, 7, "upd_bias");
    check("upd_w00", $signed(output_data[0]), 128);
    check("upd_w10", $signed(output_data[1]), 0);
    check("fwd_ie0_held", $signed(input_error[0]), 512);
    set_x(256, 0);
    run_op(1'b0, 7, "upd_c1");
    check("upd_w01", $signed(output_data[0]), 896);
    set_x(0, 256);
    run_op(1'b0, 7, "upd_c2");
    check("upd_w02", $signed(output_data[0]), 128);
    check("upd_w12", $signed(output_data[1]), 0);

    set_x(256, 0);
    dones = 0;
    @(negedge clk);
    mode = 1'b0; start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    for (int k = 8; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("held_start_dones", dones, 1);
    check("held_start_y0", $signed(output_data[0]), 896);

    @(negedge clk);
    mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1; wr_row = 1'b0; wr_col = 2'd1; wr_data = 16'd0;
    wait_done(cyc);
    check("busy_wr_done_cycle", cyc, 6);
    check("busy_wr_pass_y0", $signed(output_data[0]), 896);
    run_op(1'b0, 7, "busy_wr_after");
    check("busy_wr_after_y0", $signed(output_data[0]), 896);

    set_x(256, 256); set_e(256, 256);
    @(negedge clk);
    mode = 1'b1; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort_dones", dones, 0);
    check("abort_y0", $signed(output_data[0]), 0);
    check("abort_ie0", $signed(input_error[0]), 0);
    set_x(256, 512);
    run_op(1'b0, 7, "abort_fwd");
    check("abort_w_y0", $signed(output_data[0]), 0);
    check("abort_w_y1", $signed(output_data[1]), 0);

    set_x(256, 256);
    run_op(1'b0, 7, "samecyc", 1'b1, 0, 256);
    check("samecyc_y0", $signed(output_data[0]), 256);
    check("samecyc_y1", $signed(output_data[1]), 0);

    wr(1, 1, 1);
    set_x(-1, 0);
    run_op(1'b0, 7, "floor");
    check("floor_y0", $signed(output_data[0]), 256);
    check("floor_y1", $signed(output_data[1]), -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
